ifetch_queue: RTL

Instruction fetch and prefetch stage that sits directly upstream of the processor's execute stage. It generates sequential instruction-memory reads, buffers the returned 16-bit instruction words with their addresses in a small FIFO, and hands them to execute through a valid/ready handshake. It also takes pc redirects from execute for jr, jp8, jnz8 and jz8, which flush all buffered and in-flight words. It takes halt from sys, which stops further requests.

---
 rtl/ifetch_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Sequential instruction prefetch with a DEPTH-entry word/pc queue feeding execute.
// Optional IFQ_STOP_ON_BRANCH_EN: stall fetch after a control-flow word until brdone/redirect.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_data,
  output logic [15:0]   ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  input  logic          brdone
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   qdata [DEPTH];
  logic [AW-1:0] qpc   [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] fpc, inflight_addr;
  logic          inflight, squash;
  logic          pop, push, room, stop_req;
  logic [CW:0]   occ;

  assign ir_valid = (count != '0);
  assign pop      = ir_valid && ir_ready;
  // A response landing in the redirect cycle belongs to the old stream.
  assign push     = inflight && !squash && !redirect;

  // Words owed to the queue after this cycle's pop; a request must still fit.
  assign occ  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign room = occ < (CW+1)'(DEPTH);

`ifdef IFQ_STOP_ON_BRANCH_EN
  logic stop;

  function automatic logic is_ctrl(input logic [15:0] w);
    case (w[15:11])
      5'b10000, 5'b10010, 5'b10110, 5'b10111, 5'b10011: is_ctrl = 1'b1;
      default:                                          is_ctrl = 1'b0;
    endcase
  endfunction

  // Block the request in the very cycle a control word returns, so nothing past it is fetched.
  assign stop_req = stop || (push && is_ctrl(imem_data));

  always_ff @(posedge clk) begin
    if (reset || redirect)                stop <= 1'b0;
    else if (push && is_ctrl(imem_data))  stop <= 1'b1;
    else if (brdone)                      stop <= 1'b0;
  end
`else
  logic unused_brdone;
  assign unused_brdone = brdone;
  assign stop_req      = 1'b0;
`endif

  assign imem_req  = !reset && !halt && !redirect && room && !stop_req;
  assign imem_addr = fpc;
  assign ir        = ir_valid ? qdata[head] : '0;
  assign ir_pc     = ir_valid ? qpc[head]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc           <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      squash        <= 1'b0;
    end else begin
      inflight      <= imem_req;
      inflight_addr <= fpc;
      squash        <= redirect;
      if (redirect) begin
        fpc   <= redirect_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (imem_req) fpc  <= fpc + 1'b1;
        if (push)     tail <= tail + 1'b1;
        if (pop)      head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qdata[tail] <= imem_data;
      qpc[tail]   <= inflight_addr;
    end
  end
endmodule
